// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared constants for the instruction-fetch stage
package if_pkg;

    typedef logic [1:0] if_state_t;

    localparam if_state_t ST_IDLE    = 2'd0;
    localparam if_state_t ST_FETCH   = 2'd1;
    localparam if_state_t ST_HELD    = 2'd2;
    localparam if_state_t ST_DISCARD = 2'd3;

    localparam logic [31:0] NOP_INSTR       = 32'h0000_0000;
    localparam logic [31:0] PC_STEP_DEFAULT = 32'd4;

endpackage

// File: rtl/if_fetch_buf.sv
// rtl/if_fetch_buf.sv - instr+addr holding register used while ID is stalled
module if_fetch_buf (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        clear,
    input  logic [63:0] din,
    output logic [63:0] dout
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout <= 64'h0;
        end else if (clear) begin
            dout <= 64'h0;
        end else if (load) begin
            dout <= din;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - IF stage: PC, imem requests, IF/ID drive; IF_PERF_CNT_EN adds perf counters
module if_fetch_unit
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = PC_STEP_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] Instr,
    output logic [31:0] Addr,
    output logic        hold,
    output logic        Flush
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] bubble_cnt
`endif
);

    if_state_t   state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] pending_pc, pending_nxt;
    logic [31:0] pc_inc;
    logic        buf_load, buf_clear;
    logic [63:0] buf_q;
    logic        out_valid;

    assign pc_inc = pc + PC_STEP;

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        pending_nxt = pending_pc;
        buf_load    = 1'b0;
        buf_clear   = 1'b0;
        case (state)
            ST_IDLE: state_nxt = ST_FETCH;
            ST_FETCH: begin
                if (imem_ready) begin
                    if (redirect) begin
                        pc_nxt = redirect_pc;
                    end else if (stall) begin
                        buf_load  = 1'b1;
                        pc_nxt    = pc_inc;
                        state_nxt = ST_HELD;
                    end else begin
                        pc_nxt = pc_inc;
                    end
                end else if (redirect) begin
                    pending_nxt = redirect_pc;
                    state_nxt   = ST_DISCARD;
                end
            end
            ST_HELD: begin
                if (redirect) begin
                    buf_clear = 1'b1;
                    pc_nxt    = redirect_pc;
                    state_nxt = ST_FETCH;
                end else if (!stall) begin
                    buf_clear = 1'b1;
                    state_nxt = ST_FETCH;
                end
            end
            default: begin
                // A redirect landing in the same cycle as the stale completion is the newest target
                if (redirect) begin
                    pending_nxt = redirect_pc;
                end
                if (imem_ready) begin
                    pc_nxt    = redirect ? redirect_pc : pending_pc;
                    state_nxt = ST_FETCH;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            pc         <= RESET_PC;
            pending_pc <= RESET_PC;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            pending_pc <= pending_nxt;
        end
    end

    if_fetch_buf u_buf (
        .clk   (clk),
        .reset (reset),
        .load  (buf_load),
        .clear (buf_clear),
        .din   ({imem_rdata, pc_inc}),
        .dout  (buf_q)
    );

    assign out_valid = ((state == ST_FETCH) & imem_ready) | (state == ST_HELD);
    assign imem_req  = (state == ST_FETCH) | (state == ST_DISCARD);
    assign imem_addr = pc;

    always_comb begin
        if (state == ST_HELD) begin
            Instr = buf_q[63:32];
            Addr  = buf_q[31:0];
        end else if (out_valid) begin
            Instr = imem_rdata;
            Addr  = pc_inc;
        end else begin
            Instr = NOP_INSTR;
            Addr  = 32'h0;
        end
    end

    assign Flush = redirect | (~out_valid & ~stall) | (state == ST_IDLE);
    assign hold  = stall & (state != ST_IDLE);

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_cnt  <= 32'h0;
            bubble_cnt <= 32'h0;
        end else begin
            if (out_valid & ~stall & ~redirect) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if (Flush) begin
                bubble_cnt <= bubble_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - directed self-checking bench for if_fetch_unit
module tb_if_fetch_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] Instr;
    logic [31:0] Addr;
    logic        hold;
    logic        Flush;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] bubble_cnt;
`endif

    int errors = 0;
    int checks = 0;

    if_fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_ready  (imem_ready),
        .Instr       (Instr),
        .Addr        (Addr),
        .hold        (hold),
        .Flush       (Flush)
`ifdef IF_PERF_CNT_EN
        ,
        .fetch_cnt   (fetch_cnt),
        .bubble_cnt  (bubble_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory content is the address tagged with a fixed pattern
    assign imem_rdata = imem_addr ^ 32'hC0DE_0000;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic run_to(input logic [31:0] a);
        int n;
        n = 0;
        while (imem_addr !== a && n < 64) begin
            tick();
            n++;
        end
        checks++;
        if (imem_addr !== a) begin
            errors++;
            $display("FAIL run_to: imem_addr=%h required %h", imem_addr, a);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; stall = 1'b0; redirect = 1'b0;
        redirect_pc = 32'h0; imem_ready = 1'b1;
        tick();
        #1;
        checks++;
        if ({imem_req, Flush, hold} !== 3'b010 || Instr !== 32'h0 || Addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: req/flush/hold=%b Instr=%h Addr=%h required 010 0 0",
                     {imem_req, Flush, hold}, Instr, Addr);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_sequential();
        logic [31:0] exp_a;
        for (int i = 0; i < 4; i++) begin
            exp_a = 32'(i * 4);
            #1;
            checks++;
            if (imem_addr !== exp_a || imem_req !== 1'b1 || Addr !== exp_a + 32'd4
                || Instr !== (exp_a ^ 32'hC0DE_0000) || Flush !== 1'b0) begin
                errors++;
                $display("FAIL seq_%0d: addr=%h req=%b Addr=%h Instr=%h Flush=%b required addr=%h",
                         i, imem_addr, imem_req, Addr, Instr, Flush, exp_a);
            end
            tick();
        end
    endtask

    task automatic test_wait_states();
        imem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (imem_addr !== 32'h10 || imem_req !== 1'b1 || Flush !== 1'b1) begin
                errors++;
                $display("FAIL wait_%0d: addr=%h req=%b Flush=%b required 10 1 1", k, imem_addr, imem_req, Flush);
            end
            tick();
        end
        imem_ready = 1'b1;
        #1;
        checks++;
        if (Instr !== 32'hC0DE_0010 || Addr !== 32'h14 || Flush !== 1'b0) begin
            errors++;
            $display("FAIL wait_deliver: Instr=%h Addr=%h Flush=%b required C0DE0010 14 0", Instr, Addr, Flush);
        end
        tick();
    endtask

    task automatic test_stall();
        run_to(32'h20);
        stall = 1'b1;
        #1;
        checks++;
        if (hold !== 1'b1 || Flush !== 1'b0 || Instr !== 32'hC0DE_0020) begin
            errors++;
            $display("FAIL stall_capture: hold=%b Flush=%b Instr=%h required 1 0 C0DE0020", hold, Flush, Instr);
        end
        tick();
        #1;
        checks++;
        if (imem_req !== 1'b0 || Flush !== 1'b0 || Instr !== 32'hC0DE_0020 || Addr !== 32'h24) begin
            errors++;
            $display("FAIL stall_held: req=%b Flush=%b Instr=%h Addr=%h required 0 0 C0DE0020 24",
                     imem_req, Flush, Instr, Addr);
        end
        stall = 1'b0;
        #1;
        checks++;
        if (Instr !== 32'hC0DE_0020 || Flush !== 1'b0 || hold !== 1'b0) begin
            errors++;
            $display("FAIL stall_release: Instr=%h Flush=%b hold=%b required C0DE0020 0 0", Instr, Flush, hold);
        end
        tick();
        #1;
        checks++;
        if (imem_addr !== 32'h24 || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL stall_next: addr=%h req=%b required 24 1", imem_addr, imem_req);
        end
    endtask

    task automatic test_redirect_pending();
        run_to(32'h30);
        imem_ready = 1'b0;
        tick();
        redirect = 1'b1; redirect_pc = 32'h100;
        #1;
        checks++;
        if (Flush !== 1'b1) begin
            errors++;
            $display("FAIL discard_enter: Flush=%b required 1", Flush);
        end
        tick();
        redirect = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h30 || Flush !== 1'b1) begin
            errors++;
            $display("FAIL discard_hold: req=%b addr=%h Flush=%b required 1 30 1", imem_req, imem_addr, Flush);
        end
        tick();
        imem_ready = 1'b1;
        #1;
        checks++;
        if (Flush !== 1'b1 || Instr !== 32'h0) begin
            errors++;
            $display("FAIL discard_drop: Flush=%b Instr=%h required 1 0", Flush, Instr);
        end
        tick();
        #1;
        checks++;
        if (imem_addr !== 32'h100 || imem_req !== 1'b1 || Instr !== 32'hC0DE_0100) begin
            errors++;
            $display("FAIL discard_target: addr=%h req=%b Instr=%h required 100 1 C0DE0100",
                     imem_addr, imem_req, Instr);
        end
    endtask

    task automatic test_redirect_held();
        stall = 1'b1;
        tick();
        #1;
        checks++;
        if (imem_req !== 1'b0 || Instr !== 32'hC0DE_0100) begin
            errors++;
            $display("FAIL held_state: req=%b Instr=%h required 0 C0DE0100", imem_req, Instr);
        end
        redirect = 1'b1; redirect_pc = 32'h200;
        #1;
        checks++;
        if (Flush !== 1'b1) begin
            errors++;
            $display("FAIL held_redirect_flush: Flush=%b required 1", Flush);
        end
        tick();
        redirect = 1'b0; stall = 1'b0;
        #1;
        checks++;
        if (imem_addr !== 32'h200 || Flush !== 1'b0 || Instr !== 32'hC0DE_0200) begin
            errors++;
            $display("FAIL held_redirect_target: addr=%h Flush=%b Instr=%h required 200 0 C0DE0200",
                     imem_addr, Flush, Instr);
        end
        tick();
    endtask

    task automatic test_wrap();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        #1;
        checks++;
        if (imem_addr !== 32'hFFFF_FFFC || Addr !== 32'h0) begin
            errors++;
            $display("FAIL wrap_top: addr=%h Addr=%h required FFFFFFFC 0", imem_addr, Addr);
        end
        tick();
        #1;
        checks++;
        if (imem_addr !== 32'h0 || Addr !== 32'h4) begin
            errors++;
            $display("FAIL wrap_zero: addr=%h Addr=%h required 0 4", imem_addr, Addr);
        end
    endtask

    task automatic test_reset_mid_fetch();
        redirect = 1'b1; redirect_pc = 32'h40;
        tick();
        redirect = 1'b0; imem_ready = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin
            errors++;
            $display("FAIL midreset_pre: req=%b addr=%h required 1 40", imem_req, imem_addr);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0 || Flush !== 1'b1 || Instr !== 32'h0 || Addr !== 32'h0) begin
            errors++;
            $display("FAIL midreset_now: req=%b Flush=%b Instr=%h Addr=%h required 0 1 0 0",
                     imem_req, Flush, Instr, Addr);
        end
`ifdef IF_PERF_CNT_EN
        checks++;
        if (fetch_cnt !== 32'h0 || bubble_cnt !== 32'h0) begin
            errors++;
            $display("FAIL midreset_cnt: fetch=%0d bubble=%0d required 0 0", fetch_cnt, bubble_cnt);
        end
`endif
        tick();
        reset = 1'b1; imem_ready = 1'b1;
        tick();
        #1;
        checks++;
        if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL midreset_restart: addr=%h req=%b required 0 1", imem_addr, imem_req);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_wait_states();
        test_stall();
        test_redirect_pending();
        test_redirect_held();
        test_wrap();
        test_reset_mid_fetch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
